// File: rtl/he_enc_sched_pkg.sv
// he_enc_sched_pkg: sizing helpers and scheduler state encodings
package he_enc_sched_pkg;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int get_m(input int k);
    int m = 1;
    while ((1 << m) < k + m + 1) m++;
    return m;
  endfunction
endpackage

// File: rtl/he_enc_sched_if.sv
// he_enc_sched_if: requester, encoder and consumer buses of the encoder scheduler
interface he_enc_sched_if #(
  parameter int N_REQ = 4,
  parameter int K = 4,
  parameter int M = 3,
  parameter int IDW = 2
);
  logic [N_REQ-1:0] req_vld;
  logic [N_REQ-1:0] req_rdy;
  logic [N_REQ*K-1:0] req_data;
  logic [K-1:0] enc_din;
  logic enc_dvld;
  logic [K+M-1:0] enc_cout;
  logic enc_cvld;
  logic [K+M-1:0] out_code;
  logic [IDW-1:0] out_id;
  logic out_vld;
  logic out_rdy;
  modport master (
    input req_vld, req_data, enc_cout, enc_cvld, out_rdy,
    output req_rdy, enc_din, enc_dvld, out_code, out_id, out_vld
  );
  modport slave (
    output req_vld, req_data, enc_cout, enc_cvld, out_rdy,
    input req_rdy, enc_din, enc_dvld, out_code, out_id, out_vld
  );
endinterface

// File: rtl/he_enc_sched_fifo.sv
// he_sched_fifo: synchronous FIFO holding codeword plus requester ID
module he_sched_fifo
  import he_enc_sched_pkg::*;
#(
  parameter int W = 9,
  parameter int D = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = clog2(D);
  localparam int OW = AW + 1;
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ;
  assign full = occ == OW'(D);
  assign empty = occ == '0;
  assign dout = mem[rp];
  // storage, power-of-two pointers wrap naturally; push on full is legal alongside a pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end
endmodule

// File: rtl/he_enc_sched.sv
// he_enc_sched: round-robin sharing of one Hamming encoder among N_REQ requesters (option: HE_ENC_SCHED_PRIO0_EN)
module he_enc_sched
  import he_enc_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int K = 4,
  parameter int M = get_m(K),
  parameter int LAT = 2,
  parameter int FIFO_D = 4,
  parameter int IDW = clog2(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  he_enc_sched_if.master bus,
  input  logic flush,
  output logic flush_done,
  output logic err_unexp
);
`ifdef HE_ENC_SCHED_PRIO0_EN
  localparam bit P0 = 1'b1;
`else
  localparam bit P0 = 1'b0;
`endif
  localparam int CW = clog2(FIFO_D) + 1;
  localparam int W = K + M + IDW;
  logic [K-1:0] words [N_REQ];
  logic [IDW-1:0] ptr, gnt, idx, iss_id;
  logic [IDW-1:0] tid [1:LAT];
  logic [LAT:1] tv;
  logic [CW-1:0] count;
  logic [0:0] state;
  logic found, can_issue, hs, push, pop, lost, full, empty;
  logic [W-1:0] dout;
  for (genvar i = 0; i < N_REQ; i++) assign words[i] = bus.req_data[i*K +: K];
  // first valid requester from the pointer; requester 0 pre-empts the search when prioritised
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req_vld[idx] && !(P0 && idx == '0)) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    if (P0 && bus.req_vld[0]) begin
      found = 1'b1;
      gnt = '0;
    end
  end
  assign can_issue = count < CW'(FIFO_D) && state == RUN;
  assign hs = found && can_issue;
  assign bus.req_rdy = hs ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt : '0;
  assign lost = tv[LAT] && !bus.enc_cvld;
  assign push = bus.enc_cvld && tv[LAT] && (!full || pop);
  assign pop = !empty && bus.out_rdy;
  assign bus.out_vld = !empty;
  assign bus.out_code = dout[W-1:IDW];
  assign bus.out_id = dout[IDW-1:0];
  assign flush_done = state == DRAIN && count == '0;
  // issue register feeding the encoder and the round-robin pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.enc_din <= '0;
      bus.enc_dvld <= 1'b0;
      iss_id <= '0;
      ptr <= '0;
    end else begin
      bus.enc_dvld <= hs;
      if (hs) begin
        bus.enc_din <= words[gnt];
        iss_id <= gnt;
        if (!(P0 && gnt == '0)) ptr <= gnt == IDW'(N_REQ - 1) ? '0 : gnt + 1'b1;
      end
    end
  // tag pipeline: stage LAT lines up with the encoder's cvld
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tv <= '0;
      for (int k = 1; k <= LAT; k++) tid[k] <= '0;
    end else begin
      tv[1] <= bus.enc_dvld;
      tid[1] <= iss_id;
      for (int k = 2; k <= LAT; k++) begin
        tv[k] <= tv[k-1];
        tid[k] <= tid[k-1];
      end
    end
  // credits, drain state and sticky tag/cvld disagreement flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      state <= RUN;
      err_unexp <= 1'b0;
    end else begin
      count <= count + CW'(hs) - CW'(pop) - CW'(lost);
      state <= state == RUN ? (flush ? DRAIN : RUN) : (count == '0 ? RUN : DRAIN);
      err_unexp <= err_unexp | (bus.enc_cvld ^ tv[LAT]);
    end
  he_sched_fifo #(.W(W), .D(FIFO_D)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({bus.enc_cout, tid[LAT]}),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/he_enc_sched.md
Name: he_enc_sched

Overview:
- Round-robin scheduler that shares one Hamming encoder (he_top) between N_REQ independent data requesters.
- Accepts words over per-requester valid/ready, issues one word per cycle to the encoder, and tracks each word's requester ID through the encoder's fixed latency.
- Buffers returned codewords with their ID in an output FIFO that has consumer back-pressure.
- Sits between the data sources and he_top, and between he_top and the downstream consumer/checker.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- K, 4, data width in bits.
- M, 3, parity bits; top level sets it via get_m(K).
- LAT, 2, he_top latency in cycles from dvld to cvld (>=1).
- FIFO_D, 4, output FIFO depth (power of 2, >=2).
- IDW, 2, ID width, clog2(N_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_vld  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*K  packed words; requester i occupies bits [i*K +: K].
- req_rdy  out  N_REQ  per-requester accept.
- enc_din  out  K  to he_top din.
- enc_dvld  out  1  to he_top dvld.
- enc_cout  in  K+M  from he_top cout.
- enc_cvld  in  1  from he_top cvld.
- out_code  out  K+M  buffered codeword.
- out_id  out  IDW  requester ID of out_code.
- out_vld  out  1  FIFO non-empty.
- out_rdy  in  1  consumer accept.
- flush  in  1  drain request, sampled as a level.
- flush_done  out  1  one-cycle pulse when the drain completes.
- err_unexp  out  1  sticky flag: enc_cvld arrived with no tracked word.

Behaviour:
- Reset (rst=0, async) clears:
  - all outputs to 0;
  - RR pointer to 0;
  - credit count to 0;
  - tag pipeline valids to 0;
  - FIFO pointers, occupancy and contents;
  - state to RUN.
- Reset mid-operation discards all in-flight and buffered words.
- After reset deasserts, issue is permitted from the first rising edge.
- Credit count = words issued but not yet popped from the FIFO (in-flight plus FIFO occupancy).
  - can_issue = (count < FIFO_D) and (state == RUN).
  - Issue and pop in the same cycle leave count unchanged.
  - count never exceeds FIFO_D, so the FIFO can never overflow.
- Grant (combinational):
  - Search for the first requester with req_vld=1, starting at the RR pointer and wrapping modulo N_REQ.
  - req_rdy[g] = can_issue for the granted requester g; all other req_rdy bits are 0.
  - req_rdy never depends combinationally on anything except req_vld, the pointer, count and state.
- Issue:
  - On a handshake (req_vld[g] & req_rdy[g]) at edge t, the registered enc_din/enc_dvld present the word at cycle t+1.
  - The pointer becomes (g+1) mod N_REQ.
  - With no handshake, the pointer holds and enc_dvld=0 (enc_din holds its last value).
- Tag pipeline:
  - Shift register of {valid, ID}, LAT stages, aligned so stage LAT is valid exactly when enc_cvld is expected.
  - When enc_cvld=1 and the tag is valid, {enc_cout, tag ID} is written to the FIFO.
  - When enc_cvld=1 and the tag is invalid, err_unexp is set (cleared only by reset) and the data is dropped.
  - When the tag is valid but enc_cvld=0, err_unexp is also set and that word's credit is released.
- End-to-end latency: handshake edge t gives out_vld=1 at cycle t+LAT+2 earliest (empty FIFO).
- FIFO:
  - Registered output.
  - out_vld = not empty; pop on out_vld & out_rdy.
  - Simultaneous push and pop when full is legal (the credit scheme guarantees a pop frees the slot).
  - Read and write pointers wrap modulo FIFO_D.
- State machine (2 states):
  - RUN -> DRAIN when flush=1.
  - DRAIN: no issue; req_rdy is all 0.
  - DRAIN -> RUN when count==0; flush_done pulses for 1 cycle in that transition cycle.
  - A flush with count already 0 gives DRAIN for one cycle, then flush_done.
  - flush held high re-enters DRAIN the cycle after returning to RUN.

Optional Feature:
- Macro HE_ENC_SCHED_PRIO0_EN.
- Defined: requester 0 has strict priority. Whenever req_vld[0]=1 it is granted, regardless of the RR pointer, and the pointer is not updated. The other requesters are served round-robin among themselves.
- Undefined: pure round-robin across all N_REQ requesters.

Decomposition:
- Shared params include (alongside he_params.v) holds:
  - get_m function;
  - clog2 function used to derive IDW;
  - state encodings RUN=1'b0, DRAIN=1'b1.
- One natural sub-module: he_sched_fifo, a parameterized synchronous FIFO (width K+M+IDW, depth FIFO_D) with push, pop, full, empty and dout.
- Grant logic, tag pipeline, credit counter and FSM stay in he_enc_sched.

Test Plan:
- All 4 requesters hold vld=1, out_rdy=1: grants cycle 0,1,2,3,0,... (one per cycle); out_id follows the same order; first out_vld at 4 cycles after the first handshake (LAT=2).
- Only requester 2 valid, 6 words, out_rdy=0: exactly 4 handshakes, then req_rdy=0. Raise out_rdy: one pop per cycle frees a credit and issue resumes; all 6 IDs = 2, data in order.
- Assert flush with 3 words in flight and out_rdy=1: req_rdy=0 from the next cycle; flush_done is a single pulse when the 3rd word pops; RUN resumes and grants continue from the saved pointer.
- Inject enc_cvld=1 with no prior issue: err_unexp=1 and stays set; FIFO stays empty.
- Pulse rst low with 2 words in FIFO and 1 in flight: all outputs 0 immediately (async); after release, a fresh single request produces exactly 1 output.
- With HE_ENC_SCHED_PRIO0_EN and requesters 0 and 1 always valid: only ID 0 is granted. Drop req_vld[0] and requester 1 is granted the next cycle.
